// File: rtl/mem_arbiter_if.sv
// Request/RAM bus shared by mem_arbiter and whatever drives it.
// The slave modport is the arbiter's view; the master modport drives requests and models the RAM.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic [1:0]        ramstate;
    logic [DATA_W-1:0] ramload;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic              iwait;
    logic              dwait;
    logic [DATA_W-1:0] iload;
    logic [DATA_W-1:0] dload;
    logic              merr;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
        output ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload, merr
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
        input  ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload, merr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-ported RAM arbiter between instruction fetch (I) and data path (D), D has priority.
// Optional MEMARB_STARVE_EN: forces an I grant after STARVE_LIMIT D completions with I pending.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic           CLK,
    input logic           nRST,
    mem_arbiter_if.slave  bus
);
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("mem_arbiter: STARVE_LIMIT must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

    state_t            state;
    logic              ram_ren, ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_store;

    logic done, i_done, d_done, arb, d_req, force_i, grant_d, grant_i;

    assign done   = (state != IDLE) &&
                    (bus.ramstate == RAM_ACCESS || bus.ramstate == RAM_ERROR);
    assign i_done = done && (state == IGNT);
    assign d_done = done && (state == DGNT);
    // Arbitrate in the completion cycle too, so back-to-back grants have no bubble
    assign arb    = (state == IDLE) || done;
    assign d_req  = bus.dREN || bus.dWEN;

`ifdef MEMARB_STARVE_EN
    localparam int CNT_W = ($clog2(STARVE_LIMIT + 1) < 3) ? 3 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 1'b1;
    // The completing D access counts toward the limit in the same arbitration
    assign force_i = bus.iREN && !i_done &&
                     (d_done ? (cnt_inc >= LIMIT) : (starve_cnt >= LIMIT));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)       starve_cnt <= '0;
        else if (i_done) starve_cnt <= '0;
        else if (d_done) starve_cnt <= bus.iREN ? cnt_inc : '0;
    end
`else
    assign force_i = 1'b0;
`endif

    assign grant_d = d_req && !force_i;
    assign grant_i = bus.iREN && !grant_d;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            ram_ren   <= 1'b0;
            ram_wen   <= 1'b0;
            ram_addr  <= '0;
            ram_store <= '0;
        end else if (arb) begin
            if (grant_d) begin
                state     <= DGNT;
                ram_ren   <= bus.dREN;
                ram_wen   <= bus.dWEN;
                ram_addr  <= bus.daddr;
                ram_store <= bus.dWEN ? bus.dstore : '0;
            end else if (grant_i) begin
                state     <= IGNT;
                ram_ren   <= 1'b1;
                ram_wen   <= 1'b0;
                ram_addr  <= bus.iaddr;
                ram_store <= '0;
            end else begin
                state     <= IDLE;
                ram_ren   <= 1'b0;
                ram_wen   <= 1'b0;
                ram_addr  <= '0;
                ram_store <= '0;
            end
        end
    end

    assign bus.ramREN   = ram_ren;
    assign bus.ramWEN   = ram_wen;
    assign bus.ramaddr  = ram_addr;
    assign bus.ramstore = ram_store;
    assign bus.iwait    = !i_done;
    assign bus.dwait    = !d_done;
    assign bus.iload    = i_done ? bus.ramload : '0;
    assign bus.dload    = (d_done && ram_ren) ? bus.ramload : '0;
    assign bus.merr     = done && (bus.ramstate == RAM_ERROR);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, I-only, conflict, error, flush and starvation vectors.
// Inputs change at the falling edge; outputs are checked 1-2 time units later, before the rising edge.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .CLK  (clk),
        .nRST (rst_n),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        bus.iREN = 0; bus.iaddr = '0;
        bus.dREN = 0; bus.dWEN = 0; bus.daddr = '0; bus.dstore = '0;
        bus.ramstate = 2'd0; bus.ramload = '0;
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        idle_in();
        #2;
        // reset state
        chk("rst_ren",   bus.ramREN, 0);
        chk("rst_wen",   bus.ramWEN, 0);
        chk("rst_addr",  bus.ramaddr, 0);
        chk("rst_store", bus.ramstore, 0);
        chk("rst_waits", {bus.iwait, bus.dwait}, 2'b11);
        chk("rst_loads", {bus.iload, bus.dload}, 0);
        chk("rst_merr",  bus.merr, 0);
        nxt(); rst_n = 1;

        // I only: two BUSY then ACCESS
        nxt(); bus.iREN = 1; bus.iaddr = 32'h40; #1;
        chk("i_idle_ren", bus.ramREN, 0);
        nxt(); bus.iREN = 0; bus.ramstate = 2'd1; #1;
        chk("i_c1", {bus.ramREN, bus.ramaddr, bus.iwait}, {1'b1, 32'h40, 1'b1});
        nxt(); #1;
        chk("i_c2", {bus.ramREN, bus.ramaddr, bus.iwait}, {1'b1, 32'h40, 1'b1});
        nxt(); bus.ramstate = 2'd2; bus.ramload = 32'hDEADBEEF; #1;
        chk("i_c3", {bus.ramREN, bus.ramaddr, bus.iwait, bus.dwait}, {1'b1, 32'h40, 1'b0, 1'b1});
        chk("i_iload", bus.iload, 32'hDEADBEEF);
        chk("i_dload", bus.dload, 0);
        nxt(); idle_in(); #1;
        chk("i_after", {bus.ramREN, bus.ramaddr, bus.iwait, bus.iload}, {1'b1 ^ 1'b1, 32'h0, 1'b1, 32'h0});

        // Conflict: D write wins, I follows with no idle cycle
        nxt(); bus.iREN = 1; bus.iaddr = 32'h44; bus.dWEN = 1; bus.daddr = 32'h80; bus.dstore = 32'h1234; #1;
        nxt(); bus.dWEN = 0; bus.ramstate = 2'd2; #1;
        chk("cf_d", {bus.ramWEN, bus.ramREN, bus.ramaddr, bus.ramstore},
                    {1'b1, 1'b0, 32'h80, 32'h1234});
        chk("cf_dwait", {bus.iwait, bus.dwait}, 2'b10);
        nxt(); bus.iREN = 0; bus.ramstate = 2'd0; #1;
        chk("cf_i", {bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore},
                    {1'b1, 1'b0, 32'h44, 32'h0});
        chk("cf_iwait_hold", {bus.iwait, bus.dwait}, 2'b11);
        nxt(); bus.ramstate = 2'd2; bus.ramload = 32'h0BAD; #1;
        chk("cf_idone", {bus.iwait, bus.dwait, bus.iload}, {2'b01, 32'h0BAD});
        nxt(); idle_in(); #1;
        chk("cf_idle", {bus.ramREN, bus.ramWEN}, 2'b00);

        // Error on D read
        nxt(); bus.dREN = 1; bus.daddr = 32'h10; #1;
        chk("er_pre_merr", bus.merr, 0);
        nxt(); bus.dREN = 0; bus.ramstate = 2'd3; bus.ramload = 32'h77; #1;
        chk("er_done", {bus.dwait, bus.merr, bus.iwait}, 3'b011);
        nxt(); bus.ramstate = 2'd0; #1;
        chk("er_idle", {bus.ramREN, bus.merr, bus.dwait}, 3'b001);

        // Flush: dREN drops after grant, read still completes once
        nxt(); bus.dREN = 1; bus.daddr = 32'h20; #1;
        nxt(); bus.dREN = 0; bus.ramstate = 2'd1; #1;
        chk("fl_hold", {bus.ramREN, bus.ramaddr, bus.dwait}, {1'b1, 32'h20, 1'b1});
        nxt(); bus.ramstate = 2'd2; bus.ramload = 32'h55; #1;
        chk("fl_done", {bus.dwait, bus.dload, bus.iload}, {1'b0, 32'h55, 32'h0});
        nxt(); bus.ramstate = 2'd0; #1;
        chk("fl_idle", {bus.ramREN, bus.dwait, bus.dload}, {1'b0, 1'b1, 32'h0});

        // Reset asserted mid-DGNT
        nxt(); bus.dWEN = 1; bus.daddr = 32'h90; bus.dstore = 32'h99;
        nxt(); bus.dWEN = 0; bus.ramstate = 2'd1; #1;
        chk("rm_pre", bus.ramWEN, 1);
        rst_n = 0; #1;
        chk("rm_drop", {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait}, 4'b0011);
        chk("rm_addr", bus.ramaddr, 0);
        nxt(); rst_n = 1; idle_in();

        // Both sides continuous, RAM answers ACCESS every cycle
        nxt(); bus.iREN = 1; bus.dREN = 1; bus.iaddr = 32'h4; bus.daddr = 32'h8; bus.ramstate = 2'd2;
        for (int k = 0; k < 20; k++) begin
            logic [1:0] exp_w;
            nxt(); #1;
`ifdef MEMARB_STARVE_EN
            exp_w = (k % 5 == 4) ? 2'b01 : 2'b10;
`else
            exp_w = 2'b10;
`endif
            chk($sformatf("sv_%0d", k), {bus.iwait, bus.dwait}, exp_w);
        end
        nxt(); idle_in();
        nxt();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
